word_serial_tx: RTL and testbench
=================================

Name: word_serial_tx

Overview:
- Serial transmitter for the team's 10-bit word datapath: accepts one parallel word per valid/ready handshake and shifts it out as a framed single-wire bit stream.
- Frame: start bit, data LSB-first, optional even-parity bit, stop bit.
- Transmit end of the existing word serial link; pairs with the line receiver on the far side.
- Synthesizable block with an always_ff state machine and a combinational next-state/output section.

Parameters:
- WIDTH, 10, data word width in bits (≥1).
- CLKS_PER_BIT, 4, clock cycles per serial bit (≥2).
- PARITY_EN, 1, 1 = append even-parity bit after data; 0 = no parity bit.

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_valid  input  1  upstream word valid.
- o_ready  output  1  block can accept a word this cycle.
- i_data  input  WIDTH  word to transmit; sampled only on the accept cycle.
- o_tx  output  1  serial line; idles high.
- o_busy  output  1  frame in progress (any state other than IDLE).
- o_done  output  1  one-cycle pulse on the final cycle of the stop bit.

Behaviour:
- Reset (i_rst=1 at an edge): state IDLE, o_tx=1, o_ready=1, o_busy=0, o_done=0; shift register, bit counter and tick counter cleared. Reset mid-frame aborts the frame; o_tx is high on the next cycle.
- Outputs are registered. o_ready is 1 only in IDLE.
- Accept: i_valid & o_ready at an edge latches i_data into the shift register and moves to START. o_tx goes low on the cycle after the accept. i_valid without o_ready is ignored; upstream holds the word.
- Tick counter counts 0..CLKS_PER_BIT-1. Each bit is held for exactly CLKS_PER_BIT cycles. Wrap to 0 advances the bit.
- States:
  - IDLE: o_tx=1. On accept -> START.
  - START: o_tx=0 for one bit time -> DATA.
  - DATA: o_tx = shift[0]. Shift right each bit time. Bit counter runs 0..WIDTH-1. After bit WIDTH-1 -> PARITY if PARITY_EN, else STOP.
  - PARITY: o_tx = XOR-reduce of the latched word (even parity: total ones, including the parity bit, is even). One bit time -> STOP.
  - STOP: o_tx=1 for one bit time. o_done=1 on its last cycle. -> IDLE.
- Frame length: (WIDTH + 2 + PARITY_EN) × CLKS_PER_BIT cycles, measured from the first low cycle of o_tx.
- Minimum spacing between accepts is one frame plus 1 IDLE cycle. With i_valid held high, the next accept occurs on the first IDLE cycle.
- Parity is computed from the latched word at accept, not from the live i_data.
- No counter may overflow. Bit counter width is clog2(WIDTH+1); tick counter width is clog2(CLKS_PER_BIT).

Decomposition:
- Shared package holds:
  - state enum typedef (IDLE, START, DATA, PARITY, STOP);
  - function calc_even_parity(word) returning the XOR reduction;
  - the DEFAULT_CLKS_PER_BIT constant.
- One sub-module, serial_tick_gen: counts 0..CLKS_PER_BIT-1 while enabled and emits a one-cycle o_tick on wrap. Cleared by i_rst or when disabled.
- The receiver reuses both the package and serial_tick_gen.

Test Plan (WIDTH=10, CLKS_PER_BIT=4, PARITY_EN=1 unless stated):
- Reset idle: hold i_rst 3 cycles, then release with i_valid=0 -> o_tx=1, o_ready=1, o_busy=0, o_done=0 for 20 cycles.
- Single frame: accept i_data=10'h2A5. Required o_tx sequence, each bit held 4 cycles:
  - 0 (start);
  - 1,0,1,0,0,1,0,1,0,1 (data LSB-first);
  - 1 (parity, five ones);
  - 1 (stop).
  - o_done pulses on cycle 52 after the first low; o_ready=0 throughout.
- Back-to-back: i_valid held high with 10'h000 then 10'h3FF.
  - Second start bit begins exactly 53 cycles after the first.
  - Parity bits 0 and 0.
  - Exactly one o_done per frame.
- Ignored valid: pulse i_valid with 10'h155 during the DATA state of an ongoing frame -> no effect on the current frame and no extra frame afterwards.
- Reset mid-frame: assert i_rst in DATA bit 4 -> next cycle o_tx=1, o_busy=0, o_ready=1, no o_done. A fresh accept of 10'h001 then yields a correct full frame.
- PARITY_EN=0, CLKS_PER_BIT=2, data 10'h001 -> 12-bit frame, 24 cycles; bit sequence 0,1,0×9,1.

Source files
------------

// File: rtl/word_serial_tx_pkg.sv
// Shared definitions for the word serial link (transmitter and receiver).
// Holds the frame state encoding, the parity helper and the default bit timing.
package word_serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 4;

    // Words are zero-extended into this width, so the link supports up to 64-bit words.
    localparam int PARITY_MAX_W = 64;

    function automatic logic calc_even_parity(input logic [PARITY_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/word_serial_tx_tick_gen.sv
// Bit-time generator: counts 0..CLKS_PER_BIT-1 while enabled, pulses o_tick on the wrap cycle.
// Shared with the line receiver; held at zero while disabled or in reset.
module serial_tick_gen
    import word_serial_tx_pkg::*;
#(
    parameter int  CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic             o_tick,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        o_tick = i_en && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
        cnt_d  = cnt_q;
        if (!i_en || o_tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/word_serial_tx.sv
// Word serial link transmitter: start bit, data LSB-first, optional even parity, stop bit.
// All outputs come straight from flops; they are computed from the next state.
module word_serial_tx
    import word_serial_tx_pkg::*;
#(
    parameter int WIDTH        = 10,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_EN    = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_tx,
    output logic             o_busy,
    output logic             o_done
);

    localparam int BCNT_W = $clog2(WIDTH + 1);
    localparam int TCNT_W = $clog2(CLKS_PER_BIT);

    tx_state_e          state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [BCNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic               par_q, par_d;
    logic               tx_q, tx_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               tick;
    logic [TCNT_W-1:0]  tick_cnt;

    serial_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tick_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (state_q != IDLE),
        .o_tick (tick),
        .o_cnt  (tick_cnt)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;

        case (state_q)
            IDLE: begin
                if (i_valid && ready_q) begin
                    shift_d   = i_data;
                    par_d     = calc_even_parity(PARITY_MAX_W'(i_data));
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == BCNT_W'(WIDTH - 1)) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) state_d = STOP;
            end
            STOP: begin
                if (tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Line level for the cycle after this edge, so o_tx needs no output decode.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_q == STOP) && (tick_cnt == TCNT_W'(CLKS_PER_BIT - 2));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_tx    = tx_q;
    assign o_ready = ready_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_word_serial_tx.sv
// Bench for word_serial_tx: directed and random frames compared with a bit-list frame model.
module tb_word_serial_tx;

    localparam int C_A = 4;
    localparam int C_B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst, valid, rst2, valid2;
    logic [9:0] data, data2;
    logic       ready, tx, busy, done;
    logic       ready2, tx2, busy2, done2;

    word_serial_tx #(.WIDTH(10), .CLKS_PER_BIT(C_A), .PARITY_EN(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
        .i_data(data), .o_tx(tx), .o_busy(busy), .o_done(done)
    );

    word_serial_tx #(.WIDTH(10), .CLKS_PER_BIT(C_B), .PARITY_EN(0)) dut2 (
        .i_clk(clk), .i_rst(rst2), .i_valid(valid2), .o_ready(ready2),
        .i_data(data2), .o_tx(tx2), .o_busy(busy2), .o_done(done2)
    );

    int checks = 0;
    int passed = 0;
    int last_start = 0;
    int prev_start = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frame model: list the line levels bit by bit, then stretch each over cpb cycles.
    function automatic void build_frame(input logic [9:0] w, input int cpb, input int pen,
                                        output logic [127:0] wave, output int len);
        bit bits[$];
        bits.push_back(1'b0);
        for (int k = 0; k < 10; k++) bits.push_back(w[k]);
        if (pen != 0) bits.push_back(($countones(w) % 2) == 1);
        bits.push_back(1'b1);
        len  = bits.size() * cpb;
        wave = '0;
        for (int i = 0; i < len; i++) wave[i] = bits[i / cpb];
    endfunction

    task automatic frame_a(input logic [9:0] w, input logic nv, input logic [9:0] nd,
                           input int pulse_at, input string tag);
        logic [127:0] exp_w, obs_w;
        int len, n, ndone, done_at, rdy_hi, busy_lo;
        build_frame(w, C_A, 1, exp_w, len);
        valid = 1'b1;
        data  = w;
        n = 0;
        while (!ready && n < 200) begin
            step();
            n++;
        end
        check({tag, "_ready_timeout"}, 128'(n < 200), 128'(1));
        step();
        valid = nv;
        data  = nv ? nd : 10'($urandom);
        prev_start = last_start;
        last_start = cyc;
        obs_w = '0; ndone = 0; done_at = -1; rdy_hi = 0; busy_lo = 0;
        for (int i = 0; i < len; i++) begin
            if (i == pulse_at) begin
                valid = 1'b1;
                data  = 10'h155;
            end
            if (pulse_at >= 0 && i == pulse_at + 1) valid = 1'b0;
            obs_w[i] = tx;
            if (done) begin
                ndone++;
                done_at = i;
            end
            if (ready) rdy_hi++;
            if (!busy) busy_lo++;
            step();
        end
        check({tag, "_tx_wave"}, obs_w, exp_w);
        check({tag, "_done_count"}, 128'(ndone), 128'(1));
        check({tag, "_done_pos"}, 128'(done_at), 128'(len - 1));
        check({tag, "_ready_low"}, 128'(rdy_hi), 128'(0));
        check({tag, "_busy_high"}, 128'(busy_lo), 128'(0));
        check({tag, "_idle_after"}, 128'({tx, ready, busy, done}), 128'(4'b1100));
    endtask

    task automatic frame_b(input logic [9:0] w, input string tag);
        logic [127:0] exp_w, obs_w;
        int len, n, ndone, done_at;
        build_frame(w, C_B, 0, exp_w, len);
        valid2 = 1'b1;
        data2  = w;
        n = 0;
        while (!ready2 && n < 200) begin
            step();
            n++;
        end
        check({tag, "_ready_timeout"}, 128'(n < 200), 128'(1));
        step();
        valid2 = 1'b0;
        data2  = 10'($urandom);
        obs_w = '0; ndone = 0; done_at = -1;
        for (int i = 0; i < len; i++) begin
            obs_w[i] = tx2;
            if (done2) begin
                ndone++;
                done_at = i;
            end
            step();
        end
        check({tag, "_len"}, 128'(len), 128'(24));
        check({tag, "_tx_wave"}, obs_w, exp_w);
        check({tag, "_done_count"}, 128'(ndone), 128'(1));
        check({tag, "_done_pos"}, 128'(done_at), 128'(len - 1));
        check({tag, "_idle_after"}, 128'({tx2, ready2, busy2, done2}), 128'(4'b1100));
    endtask

    initial begin
        int bad, active;
        logic [9:0] w;
        rst = 1'b1; rst2 = 1'b1; valid = 1'b0; valid2 = 1'b0; data = '0; data2 = '0;
        step(); step(); step();
        check("reset_state", 128'({tx, ready, busy, done}), 128'(4'b1100));
        rst = 1'b0; rst2 = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if ({tx, ready, busy, done} !== 4'b1100) bad++;
        end
        check("reset_idle_20", 128'(bad), 128'(0));

        frame_a(10'h2A5, 1'b0, 10'h000, -1, "single_2a5");
        step(); step();

        frame_a(10'h000, 1'b1, 10'h3FF, -1, "b2b_000");
        frame_a(10'h3FF, 1'b0, 10'h000, -1, "b2b_3ff");
        check("b2b_spacing", 128'(last_start - prev_start), 128'(53));

        step();
        frame_a(10'h0F3, 1'b0, 10'h000, 10, "ignored_valid");
        active = 0;
        for (int i = 0; i < 60; i++) begin
            if (!tx || busy || done) active++;
            step();
        end
        check("ignored_no_extra", 128'(active), 128'(0));

        valid = 1'b1;
        data  = 10'h2CB;
        step();
        valid = 1'b0;
        for (int i = 0; i < 22; i++) step();
        rst = 1'b1;
        step();
        check("midrst_state", 128'({tx, ready, busy, done}), 128'(4'b1100));
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || !tx) bad++;
            step();
        end
        check("midrst_quiet", 128'(bad), 128'(0));
        frame_a(10'h001, 1'b0, 10'h000, -1, "after_rst_001");

        for (int r = 0; r < 8; r++) begin
            w = 10'($urandom);
            for (int g = 0; g < int'($urandom_range(0, 4)); g++) step();
            frame_a(w, 1'b0, 10'h000, (r % 2 == 1) ? int'($urandom_range(4, 40)) : -1, "random");
        end

        frame_b(10'h001, "nopar_001");
        for (int r = 0; r < 3; r++) frame_b(10'($urandom), "nopar_rand");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
